// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared constants for the CPU sequencer: opcode encodings, phase encodings,
// the run/halt state type and a small helper for the ALU-opcode group.
package cpu_pkg;

  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  localparam logic [2:0] INST_ADDR  = 3'd0;
  localparam logic [2:0] INST_FETCH = 3'd1;
  localparam logic [2:0] INST_LOAD  = 3'd2;
  localparam logic [2:0] IDLE       = 3'd3;
  localparam logic [2:0] OP_ADDR    = 3'd4;
  localparam logic [2:0] OP_FETCH   = 3'd5;
  localparam logic [2:0] ALU_OP     = 3'd6;
  localparam logic [2:0] STORE      = 3'd7;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  // Opcodes that read an operand from memory and load the accumulator.
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/cpu_sequencer_phase_counter.sv
// phase_counter
// 3-bit wrapping phase counter with hold and load-5.
// Priority: rst (to 0) > load5 (to 5) > hold (keep) > increment (7 wraps to 0).
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset
//   hold  - keep current phase
//   load5 - force phase to 5 (resume from halt)
//   phase - current phase
module phase_counter
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  input  logic       load5,
  output logic [2:0] phase
);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= INST_ADDR;
    end else if (load5) begin
      phase <= OP_FETCH;
    end else if (!hold) begin
      phase <= phase + 3'd1;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
// Eight-phase instruction sequencer for a small accumulator CPU. Holds the
// run/halt state register and decodes the control strobes combinationally
// from (state, phase, opcode, zero).
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   opcode, zero    - instruction opcode and accumulator-is-zero flag
//   resume          - one-cycle pulse that leaves the halted state
//   phase           - current phase 0..7
//   sel .. dataEn   - control strobes to the datapath
//
// state  | meaning
// RUN    | phase steps 0..7 every clock, wrapping to 0
// HALTED | HLT executed; phase frozen at 4, only Halt asserted
module cpu_sequencer
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       resume,
  output logic [2:0] phase,
  output logic       sel,
  output logic       memRead,
  output logic       ldIR,
  output logic       Halt,
  output logic       incPC,
  output logic       ACCwrite,
  output logic       ldPC,
  output logic       memWrite,
  output logic       dataEn
);

  state_t     state_q, state_d;
  logic [2:0] phase_q;
  logic       hold, load5;
  logic       aluop;

  phase_counter u_phase_counter (
    .clk   (clk),
    .rst   (rst),
    .hold  (hold),
    .load5 (load5),
    .phase (phase_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // resume is only looked at while halted, so a pulse coinciding with
  // phase 4 + HLT in RUN still halts.
  always_comb begin
    state_d = state_q;
    hold    = 1'b0;
    load5   = 1'b0;
    if (state_q == RUN) begin
      if (phase_q == OP_ADDR && opcode == HLT) begin
        state_d = HALTED;
        hold    = 1'b1;
      end
    end else begin
      if (resume) begin
        state_d = RUN;
        load5   = 1'b1;
      end else begin
        hold = 1'b1;
      end
    end
  end

  // While rst is high the outputs already show the reset values, even before
  // the first clock edge has cleared the registers.
  assign phase = rst ? INST_ADDR : phase_q;
  assign aluop = is_aluop(opcode);

  always_comb begin
    sel      = 1'b0;
    memRead  = 1'b0;
    ldIR     = 1'b0;
    Halt     = 1'b0;
    incPC    = 1'b0;
    ACCwrite = 1'b0;
    ldPC     = 1'b0;
    memWrite = 1'b0;
    dataEn   = 1'b0;
    if (rst || state_q == RUN) begin
      unique case (phase)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel     = 1'b1;
          memRead = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel     = 1'b1;
          memRead = 1'b1;
          ldIR    = 1'b1;
        end
        OP_ADDR: begin
          incPC = 1'b1;
          Halt  = (opcode == HLT);
        end
        OP_FETCH: begin
          memRead = aluop;
        end
        ALU_OP: begin
          memRead = aluop;
          incPC   = (opcode == SKZ) && zero;
          ldPC    = (opcode == JMP);
          dataEn  = (opcode == STO);
        end
        STORE: begin
          memRead  = aluop;
          ACCwrite = aluop;
          ldPC     = (opcode == JMP);
          memWrite = (opcode == STO);
          dataEn   = (opcode == STO);
        end
        default: begin
          sel = 1'b1;
        end
      endcase
    end else begin
      // Halted: incPC deliberately stays low so the PC does not advance.
      Halt = 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] opcode = 3'd2;
  logic       zero = 1'b0;
  logic       resume = 1'b0;
  logic [2:0] phase;
  logic       sel, memRead, ldIR, Halt, incPC, ACCwrite, ldPC, memWrite, dataEn;

  int pass_cnt = 0;
  int total_cnt = 0;

  cpu_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .opcode   (opcode),
    .zero     (zero),
    .resume   (resume),
    .phase    (phase),
    .sel      (sel),
    .memRead  (memRead),
    .ldIR     (ldIR),
    .Halt     (Halt),
    .incPC    (incPC),
    .ACCwrite (ACCwrite),
    .ldPC     (ldPC),
    .memWrite (memWrite),
    .dataEn   (dataEn)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a phase number and a halted flag, advanced by the rules.
  int model_phase  = 0;
  bit model_halted = 0;

  always @(posedge clk) begin
    if (rst) begin
      model_phase  = 0;
      model_halted = 0;
    end else if (model_halted) begin
      if (resume) begin
        model_halted = 0;
        model_phase  = 5;
      end
    end else if (model_phase == 4 && opcode == 3'd0) begin
      model_halted = 1;
    end else begin
      model_phase = (model_phase + 1) % 8;
    end
  end

  // Expected strobes packed as {sel,memRead,ldIR,Halt,incPC,ACCwrite,ldPC,memWrite,dataEn}.
  function automatic logic [8:0] exp_ctrl(input bit halted, input int ph,
                                          input logic [2:0] op, input logic z,
                                          input logic r);
    bit s = 0, mr = 0, li = 0, h = 0, ip = 0, aw = 0, lp = 0, mw = 0, de = 0;
    bit alu = (op >= 3'd2) && (op <= 3'd5);
    if (r) begin
      s = 1;
    end else if (halted) begin
      h = 1;
    end else begin
      s  = (ph <= 3);
      mr = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
      li = (ph == 2 || ph == 3);
      h  = (ph == 4 && op == 3'd0);
      ip = (ph == 4) || (ph == 6 && op == 3'd1 && z);
      aw = (ph == 7 && alu);
      lp = (ph >= 6 && op == 3'd7);
      mw = (ph == 7 && op == 3'd6);
      de = (ph >= 6 && op == 3'd6);
    end
    return {s, mr, li, h, ip, aw, lp, mw, de};
  endfunction

  always @(negedge clk) begin
    logic [11:0] act, exp;
    logic [2:0]  mp;
    mp  = model_phase[2:0];
    act = {phase, sel, memRead, ldIR, Halt, incPC, ACCwrite, ldPC, memWrite, dataEn};
    exp = {(rst ? 3'd0 : mp), exp_ctrl(model_halted, model_phase, opcode, zero, rst)};
    check("model_cmp", int'(act), int'(exp));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [2:0] op, input logic z);
    opcode = op;
    zero   = z;
    for (int p = 0; p < 8; p++) begin
      @(negedge clk);
      check("instr_phase", int'(phase), p);
      case (op)
        3'd2: begin
          check("add_memRead", int'(memRead), int'(p != 0 && p != 4));
          check("add_ACCwrite", int'(ACCwrite), int'(p == 7));
        end
        3'd6: begin
          check("sto_dataEn", int'(dataEn), int'(p >= 6));
          check("sto_memWrite", int'(memWrite), int'(p == 7));
          check("sto_memRead", int'(memRead), int'(p >= 1 && p <= 3));
          check("sto_ACCwrite", int'(ACCwrite), 0);
        end
        3'd1: check("skz_incPC", int'(incPC), int'(p == 4 || (z && p == 6)));
        3'd7: check("jmp_ldPC", int'(ldPC), int'(p == 6 || p == 7));
        default: ;
      endcase
      cyc();
    end
  endtask

  initial begin
    @(negedge clk);
    check("rst_phase", int'(phase), 0);
    check("rst_sel", int'(sel), 1);
    check("rst_halt", int'(Halt), 0);
    cyc();
    cyc();
    rst = 1'b0;

    run_instr(3'd2, 1'b0);
    run_instr(3'd6, 1'b0);
    run_instr(3'd1, 1'b1);
    run_instr(3'd1, 1'b0);
    run_instr(3'd7, 1'b0);

    opcode = 3'd0;
    repeat (4) cyc();
    @(negedge clk);
    check("hlt_enter_phase", int'(phase), 4);
    check("hlt_enter_halt", int'(Halt), 1);
    cyc();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("halted_phase", int'(phase), 4);
      check("halted_halt", int'(Halt), 1);
      check("halted_incPC", int'(incPC), 0);
      cyc();
    end
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    @(negedge clk);
    check("resume_phase5", int'(phase), 5);
    check("resume_halt", int'(Halt), 0);
    cyc();
    @(negedge clk);
    check("resume_phase6", int'(phase), 6);
    cyc();
    @(negedge clk);
    check("resume_phase7", int'(phase), 7);
    cyc();
    @(negedge clk);
    check("resume_phase0", int'(phase), 0);

    // resume coincident with phase 4 + HLT in RUN must still halt
    repeat (4) cyc();
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    @(negedge clk);
    check("resume_run_ignored_phase", int'(phase), 4);
    check("resume_run_ignored_halt", int'(Halt), 1);
    repeat (3) cyc();

    // reset and resume together while halted
    rst    = 1'b1;
    resume = 1'b1;
    @(negedge clk);
    check("rst_in_halt_phase", int'(phase), 0);
    check("rst_in_halt_halt", int'(Halt), 0);
    cyc();
    rst    = 1'b0;
    resume = 1'b0;
    opcode = 3'd6;
    @(negedge clk);
    check("rst_wins_phase", int'(phase), 0);
    check("rst_wins_halt", int'(Halt), 0);

    // reset mid-instruction at phase 6 of STO
    repeat (6) cyc();
    check("sto_mid_phase6", int'(phase), 6);
    check("sto_mid_dataEn", int'(dataEn), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_phase", int'(phase), 0);
    check("rst_mid_memWrite", int'(memWrite), 0);
    check("rst_mid_dataEn", int'(dataEn), 0);
    cyc();

    for (int i = 0; i < 3000; i++) begin
      opcode = 3'($urandom_range(0, 7));
      zero   = 1'($urandom_range(0, 1));
      resume = ($urandom_range(0, 7) == 0);
      rst    = ($urandom_range(0, 99) == 0);
      cyc();
    end
    rst = 1'b0;
    resume = 1'b0;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter: none; opcode and phase encodings are fixed constants from the shared package.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 opcode  input  3  current instruction-register opcode: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
REQ-005 zero  input  1  accumulator-is-zero flag.
REQ-006 resume  input  1  single-cycle pulse that releases the halt state.
REQ-007 phase  output  3  current phase, 0..7.
REQ-008 sel  output  1  address mux: 1 = PC, 0 = IR operand.
REQ-009 memRead  output  1  memory read enable.
REQ-010 ldIR  output  1  instruction-register load.
REQ-011 Halt  output  1  CPU halted.
REQ-012 incPC  output  1  PC increment.
REQ-013 ACCwrite  output  1  accumulator load.
REQ-014 ldPC  output  1  PC load (jump).
REQ-015 memWrite  output  1  memory write enable.
REQ-016 dataEn  output  1  accumulator drives the data bus.

Function
REQ-017 Define ALUOP = opcode in {ADD, AND, XOR, LDA}.
REQ-018 States:
- RUN: phase advances 0→1→…→7→0, one step per clock.
- HALTED: entered from RUN only.
REQ-019 Phase-0 (INST_ADDR) outputs: sel=1; all other control outputs 0.
REQ-020 Phase-1 (INST_FETCH) outputs: sel=1, memRead=1.
REQ-021 Phase-2 (INST_LOAD) outputs: sel=1, memRead=1, ldIR=1.
REQ-022 Phase-3 (IDLE) outputs: sel=1, memRead=1, ldIR=1.
REQ-023 Phase-4 (OP_ADDR) outputs: incPC=1; Halt=(opcode==HLT).
REQ-024 Phase-5 (OP_FETCH) outputs: memRead=ALUOP.
REQ-025 Phase-6 (ALU_OP) outputs:
- memRead=ALUOP
- incPC=(opcode==SKZ && zero)
- ldPC=(opcode==JMP)
- dataEn=(opcode==STO)
REQ-026 Phase-7 (STORE) outputs:
- memRead=ALUOP
- ACCwrite=ALUOP
- ldPC=(opcode==JMP)
- memWrite=(opcode==STO)
- dataEn=(opcode==STO)
REQ-027 Control outputs are a combinational decode of (state, phase, opcode, zero); latency from an opcode change to an output change is zero cycles.
REQ-028 Halt entry: in RUN at phase 4 with opcode==HLT and resume=0, the next state is HALTED and phase holds at 4.
REQ-029 Outputs in HALTED: Halt=1 and all other control outputs 0, including incPC, so the PC does not run away.
REQ-030 Resume: resume=1 while HALTED makes the next state RUN at phase 5; the HLT instruction then completes phases 5–7 as a no-op.
REQ-031 resume while RUN is ignored, including resume=1 coincident with phase 4 and HLT; that case still halts.
REQ-032 Phase wrap: 7→0 is unconditional in RUN.
REQ-033 Opcode or zero changes outside phases 4–7 have no effect on state.

Reset
REQ-034 rst=1 at a clock edge forces state=RUN and phase=0 on the next cycle, from any state including HALTED and mid-instruction; rst has priority over resume.
REQ-035 Output values while in reset: phase=0, sel=1, all other control outputs 0, Halt=0.

Structure
REQ-036 Shared package cpu_pkg holds:
- opcode constants HLT…JMP
- phase constants INST_ADDR…STORE
- the state enum {RUN, HALTED}
REQ-037 One sub-module, phase_counter: 3-bit wrapping counter with hold and load-5 inputs, synchronous rst. cpu_sequencer contains the state register and the output decode.

Verification
REQ-038 rst high 2 cycles, then low, opcode=ADD → phases 0..7 in order; memRead high in phases 1,2,3,5,6,7; ACCwrite=1 only in phase 7; phase returns to 0 after 8 cycles.
REQ-039 opcode=STO → dataEn=1 in phases 6–7, memWrite=1 in phase 7 only, memRead=0 in phases 5–7, ACCwrite never 1.
REQ-040 opcode=SKZ → with zero=1, incPC=1 in phases 4 and 6; with zero=0, incPC=1 in phase 4 only. opcode=JMP → ldPC=1 in phases 6–7.
REQ-041 opcode=HLT → Halt=1 from phase 4; phase stays 4 for 10 cycles with incPC=0; a resume pulse gives phase 5 next cycle, Halt=0, then 6, 7, 0.
REQ-042 Reset mid-operation: rst at phase 6 with opcode=STO → next cycle phase=0, memWrite=0, dataEn=0. rst while HALTED → phase=0, Halt=0. rst and resume together → reset wins.
